padding_window_gen: RTL and testbench

//  Parametrised successor to the fixed 416-wide RGB padding stage. Accepts one image row per beat

---
 rtl/padding_window_gen_pkg.sv | 6 +
 rtl/padding_window_gen_row_pad.sv | 19 +
 rtl/padding_window_gen.sv | 112 +++++++++++
 tb/tb_padding_window_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padding_window_gen_pkg.sv
// padding_window_gen_pkg: shared pad-mode codes and FSM state encoding for the padding window generator.
package padding_window_gen_pkg;
    localparam int PAD_MODE_CONST = 0;
    localparam int PAD_MODE_REPL = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH, ST_DONE} state_e;
endpackage

// File: rtl/padding_window_gen_row_pad.sv
// padding_row_pad: widens one IMG_W-pixel row by PAD pixels each side, constant or edge-replicated.
module padding_row_pad
    import padding_window_gen_pkg::*;
#(
    parameter int DW = 8,
    parameter int IMG_W = 416,
    parameter int PAD = 1,
    parameter int PAD_MODE = 0,
    parameter int PAD_VAL = 0
)(
    input  logic [IMG_W*DW-1:0]         row_i,
    output logic [(IMG_W+2*PAD)*DW-1:0] row_o
);
    localparam logic [DW-1:0] PV = DW'(PAD_VAL);
    logic [DW-1:0] left_px, right_px;
    assign left_px = PAD_MODE == PAD_MODE_REPL ? row_i[DW-1:0] : PV;
    assign right_px = PAD_MODE == PAD_MODE_REPL ? row_i[IMG_W*DW-1 -: DW] : PV;
    assign row_o = {{PAD{right_px}}, row_i, {PAD{left_px}}};
endmodule

// File: rtl/padding_window_gen.sv
// padding_window_gen: turns a stream of image rows into K-row windows with vertical and
// horizontal padding so a KxK conv produces same-size output.
module padding_window_gen
    import padding_window_gen_pkg::*;
#(
    parameter int DW = 8,
    parameter int IMG_W = 416,
    parameter int IMG_H = 416,
    parameter int CH = 3,
    parameter int K = 3,
    parameter int PAD_MODE = 0,
    parameter int PAD_VAL = 0
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            frame_clr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CH*IMG_W*DW-1:0]          in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [K*CH*(IMG_W+K-1)*DW-1:0]  out_rows,
    output logic [$clog2(IMG_H)-1:0]        out_row_idx,
    output logic                            intr
);
    localparam int PAD = (K-1)/2;
    localparam int OW = IMG_W + 2*PAD;
    localparam int RW = CH*IMG_W*DW;
    localparam int RXW = $clog2(IMG_H+1);
    localparam int TXW = $clog2(IMG_H);
    localparam logic [DW-1:0] PV = DW'(PAD_VAL);

    if (K < 3 || K % 2 == 0) begin : g_bad_k
        $error("K must be odd and >= 3");
    end
    if (IMG_H <= PAD) begin : g_bad_h
        $error("IMG_H must exceed PAD");
    end

    state_e state_q;
    logic [RW-1:0] win_q [K];
    logic [RW-1:0] win_d [K];
    logic [RW-1:0] pad_row;
    logic [RXW-1:0] rx_q;
    logic [TXW-1:0] tx_q;
    logic full_q, intr_q;
    logic fire_in, fire_out, last_out, shift;

    assign in_ready = en && (state_q == ST_IDLE || state_q == ST_STREAM) && rx_q < RXW'(IMG_H) && (!full_q || out_ready);
    assign out_valid = en && full_q;
    assign fire_in = in_valid && in_ready;
    assign fire_out = out_valid && out_ready;
    assign last_out = fire_out && tx_q == TXW'(IMG_H-1);
    assign shift = fire_in || (fire_out && state_q == ST_FLUSH);
    assign out_row_idx = tx_q;
    assign intr = intr_q;

    // The first row of a frame stands in for the rows above the image in replicate mode
    assign pad_row = PAD_MODE == PAD_MODE_REPL ? (rx_q == '0 ? in_data : win_q[K-1]) : {(CH*IMG_W){PV}};

    always_comb begin
        for (int i = 0; i < K-1; i++) win_d[i] = rx_q == '0 ? pad_row : win_q[i+1];
        win_d[K-1] = state_q == ST_FLUSH ? pad_row : in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) win_q[i] <= '0;
            state_q <= ST_IDLE;
            rx_q <= '0;
            tx_q <= '0;
            full_q <= 1'b0;
            intr_q <= 1'b0;
        end else if (frame_clr) begin
            state_q <= ST_IDLE;
            rx_q <= '0;
            tx_q <= '0;
            full_q <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            intr_q <= last_out && state_q == ST_FLUSH;
            if (shift) for (int i = 0; i < K; i++) win_q[i] <= win_d[i];
            if (fire_in) begin
                rx_q <= rx_q + 1'b1;
                full_q <= rx_q >= RXW'(PAD);
            end else if (fire_out) begin
                full_q <= state_q == ST_FLUSH && !last_out;
            end
            if (fire_out) tx_q <= last_out ? '0 : tx_q + 1'b1;
            case (state_q)
                ST_IDLE, ST_STREAM: if (fire_in) state_q <= rx_q == RXW'(IMG_H-1) ? ST_FLUSH : ST_STREAM;
                ST_FLUSH: if (last_out) state_q <= ST_DONE;
                ST_DONE: if (en) begin
                    state_q <= ST_IDLE;
                    rx_q <= '0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_r
        for (genvar c = 0; c < CH; c++) begin : g_c
            padding_row_pad #(
                .DW(DW), .IMG_W(IMG_W), .PAD(PAD), .PAD_MODE(PAD_MODE), .PAD_VAL(PAD_VAL)
            ) u_pad (
                .row_i(win_q[r][c*IMG_W*DW +: IMG_W*DW]),
                .row_o(out_rows[(r*CH+c)*OW*DW +: OW*DW])
            );
        end
    end
endmodule

// File: tb/tb_padding_window_gen.sv
// tb_padding_window_gen: three DUTs (const 0, replicate, const A5) on shared stimulus,
// windows checked against a clamp-or-constant pixel model.
module tb_padding_window_gen;
    localparam int DW = 8, IMG_W = 4, IMG_H = 4, CH = 1, K = 3, PAD = 1, OW = 6;
    localparam int RW = CH*IMG_W*DW, OUTW = K*CH*OW*DW;

    logic clk = 0, reset = 0, en = 1, frame_clr = 0, in_valid = 0, out_ready = 1;
    logic [RW-1:0] in_data = '0;
    logic [2:0] in_ready, out_valid, intr;
    logic [OUTW-1:0] out_rows [3];
    logic [1:0] out_row_idx [3];

    for (genvar d = 0; d < 3; d++) begin : g_dut
        padding_window_gen #(
            .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .K(K),
            .PAD_MODE(d == 1 ? 1 : 0), .PAD_VAL(d == 2 ? 165 : 0)
        ) dut (
            .clk(clk), .reset(reset), .en(en), .frame_clr(frame_clr),
            .in_valid(in_valid), .in_ready(in_ready[d]), .in_data(in_data),
            .out_valid(out_valid[d]), .out_ready(out_ready), .out_rows(out_rows[d]),
            .out_row_idx(out_row_idx[d]), .intr(intr[d])
        );
    end

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, passes = 0;
    logic [7:0] rows [IMG_H][IMG_W];
    logic [OUTW-1:0] cap0[$], cap1[$], cap2[$], st_rows[$];
    int idx_q[$], acc_cyc[$], fire_cyc[$], intr_cyc[$], st_idx[$];
    logic st_rdy[$], st_vld[$], enoff_busy[$];

    function automatic logic [7:0] exp_px(int d, int w, int r, int x);
        int sr = w - PAD + r, sx = x - PAD;
        if (d != 1 && (sr < 0 || sr >= IMG_H || sx < 0 || sx >= IMG_W)) return d == 2 ? 8'hA5 : 8'h00;
        sr = sr < 0 ? 0 : (sr >= IMG_H ? IMG_H-1 : sr);
        sx = sx < 0 ? 0 : (sx >= IMG_W ? IMG_W-1 : sx);
        return rows[sr][sx];
    endfunction

    function automatic logic [OUTW-1:0] exp_win(int d, int w);
        logic [OUTW-1:0] v;
        for (int r = 0; r < K; r++)
            for (int x = 0; x < OW; x++) v[(r*OW+x)*DW +: DW] = exp_px(d, w, r, x);
        return v;
    endfunction

    function automatic logic [OUTW-1:0] get_cap(int d, int i);
        if (i >= cap0.size()) return 'x;
        return d == 0 ? cap0[i] : (d == 1 ? cap1[i] : cap2[i]);
    endfunction

    function automatic logic [RW-1:0] pack_row(int n);
        logic [RW-1:0] v = RW'($urandom);
        if (n < IMG_H) for (int x = 0; x < IMG_W; x++) v[x*DW +: DW] = rows[n][x];
        return v;
    endfunction

    task automatic set_rows(input bit spec);
        for (int n = 0; n < IMG_H; n++)
            for (int x = 0; x < IMG_W; x++) rows[n][x] = spec ? 8'(n*16 + x) : 8'($urandom);
    endtask

    task automatic clear_caps;
        cap0.delete(); cap1.delete(); cap2.delete(); st_rows.delete();
        idx_q.delete(); acc_cyc.delete(); fire_cyc.delete(); intr_cyc.delete();
        st_idx.delete(); st_rdy.delete(); st_vld.delete(); enoff_busy.delete();
    endtask

    // gap: 0 always valid, >0 valid every gap-th cycle, <0 random; en drops for 3 cycles from en_off
    task automatic drive_frame(input int gap, input int stall_pct, input int en_off, input int clr_at,
                               input int stop_at, input int stall_at, output bit to);
        int nxt = 0, fires = 0, stall_left = 0;
        bit done = 0, stalled = 0, forced;
        to = 0;
        @(posedge clk);
        for (int k = 0; !done; k++) begin
            en = !(en_off >= 0 && k >= en_off && k < en_off + 3);
            #1;
            in_valid = nxt < IMG_H && (gap == 0 || (gap > 0 ? k % gap == 0 : $urandom_range(0, 1) == 1));
            in_data = pack_row(nxt);
            if (stall_at >= 0 && !stalled && fires == stall_at && out_valid[0]) begin
                stalled = 1;
                stall_left = 5;
            end
            forced = stall_left > 0;
            if (forced) stall_left--;
            out_ready = !forced && $urandom_range(0, 99) >= stall_pct;
            @(negedge clk);
            if (forced) begin
                st_rows.push_back(out_rows[0]); st_idx.push_back(out_row_idx[0]);
                st_rdy.push_back(in_ready[0]); st_vld.push_back(out_valid[0]);
            end
            if (!en) enoff_busy.push_back(out_valid[0] | in_ready[0]);
            if (clr_at >= 0 && fires == clr_at && in_valid && in_ready[0] && out_valid[0] && out_ready) begin
                frame_clr = 1;
                done = 1;
            end else begin
                if (in_valid && in_ready[0]) begin
                    acc_cyc.push_back(cyc);
                    nxt++;
                end
                if (out_valid[0] && out_ready) begin
                    cap0.push_back(out_rows[0]); cap1.push_back(out_rows[1]); cap2.push_back(out_rows[2]);
                    idx_q.push_back(out_row_idx[0]); fire_cyc.push_back(cyc);
                    fires++;
                end
                if (intr[0]) begin
                    intr_cyc.push_back(cyc);
                    done = 1;
                end
                if (stop_at >= 0 && fires >= stop_at) done = 1;
            end
            if (k >= 2000) begin
                to = 1;
                done = 1;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 0; frame_clr = 0; en = 1; out_ready = 1;
    endtask

    task automatic test_reset;
        #1 reset = 1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({out_valid[d], intr[d], out_row_idx[d]} !== 4'b0)
                $display("FAIL reset_outs d%0d got v=%b i=%b idx=%0d want 0", d, out_valid[d], intr[d], out_row_idx[d]);
            else passes++;
        end
        checks++;
        if (out_rows[0] !== '0 || out_rows[1] !== '0) $display("FAIL reset_rows got %h / %h want 0", out_rows[0], out_rows[1]);
        else passes++;
        @(negedge clk) reset = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 3'b111) $display("FAIL reset_in_ready got %b want 111", in_ready);
        else passes++;
    endtask

    task automatic test_const_and_repl;
        bit to;
        logic [OUTW-1:0] w;
        int ref_r1 [OW] = '{16, 16, 17, 18, 19, 19};
        set_rows(1);
        clear_caps();
        drive_frame(0, 0, -1, -1, -1, -1, to);
        checks++;
        if (to || cap0.size() != IMG_H) $display("FAIL t1_count got %0d timeout=%0d want %0d", cap0.size(), to, IMG_H);
        else passes++;
        checks++;
        if (fire_cyc[0] !== acc_cyc[1] + 1) $display("FAIL t1_first_latency got %0d want %0d", fire_cyc[0], acc_cyc[1] + 1);
        else passes++;
        checks++;
        if (fire_cyc[3] !== fire_cyc[0] + 3) $display("FAIL t1_consecutive got %0d want %0d", fire_cyc[3], fire_cyc[0] + 3);
        else passes++;
        checks++;
        if (intr_cyc.size() != 1 || intr_cyc[0] !== fire_cyc[3] + 1)
            $display("FAIL t1_intr got n=%0d want intr at %0d", intr_cyc.size(), fire_cyc[3] + 1);
        else passes++;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < IMG_H; i++) begin
                checks++;
                if (get_cap(d, i) !== exp_win(d, i)) $display("FAIL t1_win d%0d w%0d got %h want %h", d, i, get_cap(d, i), exp_win(d, i));
                else passes++;
            end
        for (int i = 0; i < IMG_H; i++) begin
            checks++;
            if (idx_q[i] != i) $display("FAIL t1_idx w%0d got %0d want %0d", i, idx_q[i], i);
            else passes++;
        end
        w = get_cap(1, 1);
        for (int x = 0; x < OW; x++) begin
            checks++;
            if (w[(OW+x)*DW +: DW] !== 8'(ref_r1[x])) $display("FAIL t2_r1_px x%0d got %0d want %0d", x, w[(OW+x)*DW +: DW], ref_r1[x]);
            else passes++;
        end
        w = get_cap(0, 3);
        checks++;
        if (w[2*OW*DW +: OW*DW] !== '0) $display("FAIL t1_bottom_pad got %h want 0", w[2*OW*DW +: OW*DW]);
        else passes++;
    endtask

    task automatic test_stall;
        bit to;
        set_rows(1);
        clear_caps();
        drive_frame(0, 0, -1, -1, -1, 1, to);
        checks++;
        if (st_rows.size() != 5) $display("FAIL t3_stall_len got %0d want 5", st_rows.size());
        else passes++;
        for (int i = 0; i < st_rows.size(); i++) begin
            checks++;
            if (st_rows[i] !== exp_win(0, 1) || st_idx[i] != 1 || st_rdy[i] !== 1'b0 || st_vld[i] !== 1'b1)
                $display("FAIL t3_hold c%0d got idx=%0d rdy=%b vld=%b rows=%h want idx=1 rdy=0 vld=1 rows=%h",
                         i, st_idx[i], st_rdy[i], st_vld[i], st_rows[i], exp_win(0, 1));
            else passes++;
        end
        checks++;
        if (to || cap0.size() != IMG_H) $display("FAIL t3_count got %0d want %0d", cap0.size(), IMG_H);
        else passes++;
        for (int i = 0; i < IMG_H; i++) begin
            checks++;
            if (get_cap(0, i) !== exp_win(0, i)) $display("FAIL t3_win w%0d got %h want %h", i, get_cap(0, i), exp_win(0, i));
            else passes++;
        end
    endtask

    task automatic test_en_gap;
        bit to;
        int extra = 0;
        set_rows(1);
        clear_caps();
        drive_frame(3, 0, 6, -1, -1, -1, to);
        repeat (6) @(negedge clk) if (intr[0]) extra++;
        checks++;
        if (to || intr_cyc.size() + extra != 1) $display("FAIL t4_intr_once got %0d want 1", intr_cyc.size() + extra);
        else passes++;
        checks++;
        if (enoff_busy.size() != 3 || enoff_busy.or() !== 1'b0) $display("FAIL t4_en_freeze got n=%0d busy=%b want 3/0", enoff_busy.size(), enoff_busy.or());
        else passes++;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < IMG_H; i++) begin
                checks++;
                if (get_cap(d, i) !== exp_win(d, i)) $display("FAIL t4_win d%0d w%0d got %h want %h", d, i, get_cap(d, i), exp_win(d, i));
                else passes++;
            end
    endtask

    task automatic test_frame_clr;
        bit to;
        set_rows(1);
        clear_caps();
        drive_frame(0, 0, -1, 1, -1, -1, to);
        checks++;
        if (out_valid[0] !== 1'b0 || out_row_idx[0] !== 2'd0 || in_ready[0] !== 1'b1)
            $display("FAIL t5_after_clr got v=%b idx=%0d rdy=%b want 0/0/1", out_valid[0], out_row_idx[0], in_ready[0]);
        else passes++;
        checks++;
        if (cap0.size() != 1 || intr_cyc.size() != 0) $display("FAIL t5_counted got w=%0d intr=%0d want 1/0", cap0.size(), intr_cyc.size());
        else passes++;
        clear_caps();
        drive_frame(0, 0, -1, -1, -1, -1, to);
        checks++;
        if (to || cap0.size() != IMG_H) $display("FAIL t5_count got %0d want %0d", cap0.size(), IMG_H);
        else passes++;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < IMG_H; i++) begin
                checks++;
                if (get_cap(d, i) !== exp_win(d, i)) $display("FAIL t5_win d%0d w%0d got %h want %h", d, i, get_cap(d, i), exp_win(d, i));
                else passes++;
            end
    endtask

    task automatic test_async_reset;
        bit to;
        int n = 0;
        logic [OUTW-1:0] z;
        set_rows(0);
        clear_caps();
        drive_frame(0, 0, -1, -1, 3, -1, to);
        checks++;
        if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) $display("FAIL t6_flush got v=%b rdy=%b want 1/0", out_valid[0], in_ready[0]);
        else passes++;
        #2 reset = 1;
        #1;
        checks++;
        if (out_valid !== 3'b0 || intr !== 3'b0 || out_row_idx[0] !== 2'd0 || out_rows[0] !== '0 || out_rows[1] !== '0)
            $display("FAIL t6_reset_now got v=%b i=%b idx=%0d rows=%h want 0", out_valid, intr, out_row_idx[0], out_rows[0]);
        else passes++;
        for (int r = 0; r < K; r++)
            for (int x = 0; x < OW; x++) z[(r*OW+x)*DW +: DW] = (x < PAD || x >= OW-PAD) ? 8'hA5 : 8'h00;
        checks++;
        if (out_rows[2] !== z) $display("FAIL t6_a5_edges got %h want %h", out_rows[2], z);
        else passes++;
        @(negedge clk) reset = 0;
        repeat (6) @(negedge clk) if (|intr) n++;
        checks++;
        if (n != 0) $display("FAIL t6_no_intr got %0d want 0", n);
        else passes++;
        set_rows(0);
        clear_caps();
        drive_frame(0, 0, -1, -1, -1, -1, to);
        for (int i = 0; i < IMG_H; i++) begin
            checks++;
            if (get_cap(2, i) !== exp_win(2, i)) $display("FAIL t6_a5_win w%0d got %h want %h", i, get_cap(2, i), exp_win(2, i));
            else passes++;
        end
        z = get_cap(2, 0);
        checks++;
        if (z[0 +: OW*DW] !== {OW{8'hA5}} || z[OW*DW +: DW] !== 8'hA5) $display("FAIL t6_a5_pad got %h want A5 pad", z[0 +: 2*OW*DW]);
        else passes++;
    endtask

    task automatic test_back_to_back;
        bit to;
        for (int f = 0; f < 3; f++) begin
            set_rows(0);
            clear_caps();
            drive_frame(-1, 30, -1, -1, -1, -1, to);
            checks++;
            if (to || cap0.size() != IMG_H || intr_cyc.size() != 1)
                $display("FAIL b2b_count f%0d got w=%0d intr=%0d want %0d/1", f, cap0.size(), intr_cyc.size(), IMG_H);
            else passes++;
            for (int d = 0; d < 3; d++)
                for (int i = 0; i < IMG_H; i++) begin
                    checks++;
                    if (get_cap(d, i) !== exp_win(d, i) || idx_q[i] != i)
                        $display("FAIL b2b_win f%0d d%0d w%0d got %h idx=%0d want %h idx=%0d", f, d, i, get_cap(d, i), idx_q[i], exp_win(d, i), i);
                    else passes++;
                end
        end
    endtask

    initial begin
        test_reset();
        test_const_and_repl();
        test_stall();
        test_en_gap();
        test_frame_clr();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
